char_rom_arbiter: RTL and testbench

//   Shares one character-text ROM (12-bit char_xy in, registered 7-bit char_code out) between
//   NUM_REQ text requesters (menu, solo, multi, result overlays). Round-robin arbitration, one
//   ROM access per cycle, optional locked bursts for string reads. Returns each ROM word tagged

---
 rtl/char_rom_arbiter.sv | 171 +++++++++++++++++
 tb/tb_char_rom_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_rom_arbiter.sv
// -----------------------------------------------------------------------------
// char_rom_arbiter
//   Shares one character-text ROM (char_xy in, registered char_code out)
//   between NUM_REQ text requesters. Round-robin arbitration with optional
//   locked bursts. Each ROM word comes back tagged with the requester index,
//   ROM_LAT cycles after its grant. One access per cycle, responses in grant
//   order, no backpressure on the response side.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   req_i        per-requester request, held until granted
//   lock_i       per-requester burst lock (meaningful only together with req)
//   addr_i       per-requester char_xy, slice i = [i*ADDR_W +: ADDR_W]
//   gnt_o        one-hot grant, combinational, same cycle as the accepted req
//   rom_addr_o   char_xy to the ROM (0 when nothing is granted)
//   rom_data_i   char_code from the ROM, ROM_LAT cycles after rom_addr_o
//   rsp_valid_o  response word valid
//   rsp_id_o     requester index of the response
//   rsp_data_o   character code returned (id/data hold while rsp_valid_o=0)
// -----------------------------------------------------------------------------
module char_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 7,
    parameter int ROM_LAT   = 1,
    parameter int MAX_BURST = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    addr_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [DATA_W-1:0]            rom_data_i,
    output logic                         rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
    output logic [DATA_W-1:0]            rsp_data_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    // Arbitration state
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             owner_vld_q, owner_vld_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // Response tag pipe; the last stage lines up with rom_data_i
    logic [ROM_LAT-1:0]           vld_q;
    logic [ROM_LAT-1:0][ID_W-1:0] id_q;
    logic [ID_W-1:0]              last_id_q;
    logic [DATA_W-1:0]            last_data_q;

    logic            win_vld;
    logic [ID_W-1:0] win_idx;
    logic            forced;
    logic            own_hold;
    int              j;

    // Winner selection: a locked owner keeps the ROM until it has used
    // MAX_BURST grants; after that it competes in plain round-robin, and since
    // ptr sits just past it, it is scanned last.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        j        = 0;
        forced   = owner_vld_q && (burst_cnt_q >= MAX_CNT);
        own_hold = owner_vld_q && req_i[owner_q] && lock_i[owner_q];
        if (!rst_i) begin
            if (own_hold && !forced) begin
                win_vld = 1'b1;
                win_idx = owner_q;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = int'(ptr_q) + k;
                    if (j >= NUM_REQ) j = j - NUM_REQ;
                    if (!win_vld && req_i[j]) begin
                        win_vld = 1'b1;
                        win_idx = ID_W'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_o      = '0;
        rom_addr_o = '0;
        if (win_vld) begin
            gnt_o[win_idx] = 1'b1;
            rom_addr_o     = addr_i[win_idx*ADDR_W +: ADDR_W];
        end
    end

    // Next arbitration state. A forced release counts as "no owner", so an
    // owner that wins again afterwards starts a fresh burst at 1. An owner
    // that drops req or lock loses ownership at the next edge even when
    // nobody else is granted, so a later lock starts a new burst.
    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_cnt_d = burst_cnt_q;
        if (win_vld) begin
            ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (lock_i[win_idx]) begin
                owner_vld_d = 1'b1;
                owner_d     = win_idx;
                burst_cnt_d = (owner_vld_q && (owner_q == win_idx) && !forced)
                              ? burst_cnt_q + 1'b1 : CNT_W'(1);
            end else begin
                owner_vld_d = 1'b0;
                burst_cnt_d = '0;
            end
        end else if (owner_vld_q && !own_hold) begin
            owner_vld_d = 1'b0;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= '0;
            vld_q       <= '0;
            last_id_q   <= '0;
            last_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            for (int k = ROM_LAT - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
            end
            vld_q[0] <= win_vld;
            if (vld_q[ROM_LAT-1]) begin
                last_id_q   <= id_q[ROM_LAT-1];
                last_data_q <= rom_data_i;
            end
        end
    end

    // Tag ids carry no reset; they are only looked at when their valid is set.
    always_ff @(posedge clk_i) begin
        for (int k = ROM_LAT - 1; k > 0; k--) begin
            id_q[k] <= id_q[k-1];
        end
        id_q[0] <= win_idx;
    end

    // The live word is passed straight from the ROM register in its arrival
    // cycle; the _q copies only supply the hold value between words.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_id_o    = '0;
        rsp_data_o  = '0;
        if (!rst_i) begin
            rsp_valid_o = vld_q[ROM_LAT-1];
            rsp_id_o    = vld_q[ROM_LAT-1] ? id_q[ROM_LAT-1] : last_id_q;
            rsp_data_o  = vld_q[ROM_LAT-1] ? rom_data_i : last_data_q;
        end
    end

endmodule

// File: tb/tb_char_rom_arbiter.sv
module tb_char_rom_arbiter;

    localparam int MB = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [47:0] addr;

    logic [3:0]  gnt_a, gnt_b;
    logic [11:0] rom_addr_a, rom_addr_b;
    logic [6:0]  rom_data_a, rom_data_b;
    logic        rv_a, rv_b;
    logic [1:0]  rid_a, rid_b;
    logic [6:0]  rd_a, rd_b;
    logic [11:0] b1, b2;

    char_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(7), .ROM_LAT(1), .MAX_BURST(MB)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
        .gnt_o(gnt_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
        .rsp_valid_o(rv_a), .rsp_id_o(rid_a), .rsp_data_o(rd_a));

    char_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(7), .ROM_LAT(3), .MAX_BURST(MB)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
        .gnt_o(gnt_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
        .rsp_valid_o(rv_b), .rsp_id_o(rid_b), .rsp_data_o(rd_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] rom_f(input logic [11:0] a);
        return a[6:0] ^ {a[11:7], a[1:0]} ^ 7'h2b;
    endfunction

    // ROM models: registered output, total latency 1 and 3 cycles
    always @(posedge clk) begin
        rom_data_a <= rom_f(rom_addr_a);
        b1         <= rom_addr_b;
        b2         <= b1;
        rom_data_b <= rom_f(b2);
    end

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model state
    int m_ptr = 0, m_owner = -1, m_cnt = 0;
    int lat [2] = '{1, 3};
    bit ev  [2][16];
    int eid [2][16];
    int edat[2][16];
    int lid [2] = '{0, 0};
    int ldat[2] = '{0, 0};

    // Samples of the last cycle
    logic [3:0]  s_gnt;
    logic        av  [2];
    logic [31:0] aid [2];
    logic [31:0] adat[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        else
            passed++;
    endtask

    task automatic do_cycle(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                            input logic [47:0] ad);
        int w;
        int s;
        int slot;
        bit same;
        logic [3:0]  eg;
        logic [11:0] ea;
        rst  = r;
        req  = rq;
        lock = lk;
        addr = ad;
        @(negedge clk);
        w = -1;
        if (!r) begin
            if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && m_cnt < MB)
                w = m_owner;
            else
                for (int k = 0; k < 4; k++)
                    if (w < 0 && rq[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        eg = (w >= 0) ? 4'(1 << w) : 4'b0;
        ea = (w >= 0) ? ad[w*12 +: 12] : 12'h0;
        s_gnt = gnt_a;
        chk("gnt_a", 32'(gnt_a), 32'(eg));
        chk("gnt_b", 32'(gnt_b), 32'(eg));
        chk("rom_addr_a", 32'(rom_addr_a), 32'(ea));
        chk("rom_addr_b", 32'(rom_addr_b), 32'(ea));
        av[0] = rv_a; aid[0] = 32'(rid_a); adat[0] = 32'(rd_a);
        av[1] = rv_b; aid[1] = 32'(rid_b); adat[1] = 32'(rd_b);
        s = cyc % 16;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                chk("rsp_valid_in_rst", 32'(av[d]), 0);
                chk("rsp_id_in_rst", aid[d], 0);
                chk("rsp_data_in_rst", adat[d], 0);
            end else if (ev[d][s]) begin
                chk("rsp_valid", 32'(av[d]), 1);
                chk("rsp_id", aid[d], eid[d][s]);
                chk("rsp_data", adat[d], edat[d][s]);
                lid[d]  = eid[d][s];
                ldat[d] = edat[d][s];
            end else begin
                chk("rsp_valid_idle", 32'(av[d]), 0);
                chk("rsp_id_hold", aid[d], lid[d]);
                chk("rsp_data_hold", adat[d], ldat[d]);
            end
            ev[d][s] = 1'b0;
        end
        if (r) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 16; i++) ev[d][i] = 1'b0;
                lid[d]  = 0;
                ldat[d] = 0;
            end
            m_ptr = 0; m_owner = -1; m_cnt = 0;
        end else if (w >= 0) begin
            same = (m_owner == w) && (m_cnt < MB);
            if (lk[w]) begin
                m_cnt   = same ? m_cnt + 1 : 1;
                m_owner = w;
            end else begin
                m_cnt   = 0;
                m_owner = -1;
            end
            m_ptr = (w + 1) % 4;
            for (int d = 0; d < 2; d++) begin
                slot = (cyc + lat[d]) % 16;
                ev[d][slot]   = 1'b1;
                eid[d][slot]  = w;
                edat[d][slot] = int'(rom_f(ea));
            end
        end else if (m_owner >= 0 && !(rq[m_owner] && lk[m_owner])) begin
            m_owner = -1;
            m_cnt   = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] lk;
        logic [3:0] eg;
    } vec_t;

    vec_t tbl[18];
    logic [47:0] ad0;
    logic [47:0] ad1;
    logic [63:0] rnd;
    logic        rr;
    logic [3:0]  rq, lk;

    initial begin
        rst = 1'b1; req = '0; lock = '0; addr = '0;
        ad0 = {12'hfff, 12'h3c4, 12'h123, 12'h0ab};
        ad1 = {12'h777, 12'h555, 12'h01a, 12'h333};

        // reset with all requests, round-robin, locked burst, wrap and idle gaps
        tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'h1};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h2};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h4};
        tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h8};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h1};
        tbl[7]  = '{1'b0, 4'h5, 4'h4, 4'h4};
        tbl[8]  = '{1'b0, 4'h5, 4'h4, 4'h4};
        tbl[9]  = '{1'b0, 4'h5, 4'h4, 4'h4};
        tbl[10] = '{1'b0, 4'h5, 4'h4, 4'h4};
        tbl[11] = '{1'b0, 4'h5, 4'h4, 4'h1};
        tbl[12] = '{1'b0, 4'h5, 4'h4, 4'h4};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{1'b0, 4'h8, 4'h0, 4'h8};
        tbl[15] = '{1'b0, 4'h1, 4'h0, 4'h1};
        tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h0};
        tbl[17] = '{1'b0, 4'hF, 4'h0, 4'h2};

        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            do_cycle(tbl[i].r, tbl[i].rq, tbl[i].lk, ad0);
            chk("tbl_gnt", 32'(s_gnt), 32'(tbl[i].eg));
        end

        // Single grant: id 1 at 0x01a, watched on both latencies
        do_cycle(1'b1, 4'h0, 4'h0, ad1);
        do_cycle(1'b0, 4'h2, 4'h0, ad1);
        for (int i = 1; i <= 4; i++) begin
            do_cycle(1'b0, 4'h0, 4'h0, ad1);
            chk("lat3_valid", 32'(av[1]), 32'(i == 3));
            chk("lat1_valid", 32'(av[0]), 32'(i == 1));
            if (i == 3) begin
                chk("lat3_id", aid[1], 1);
                chk("lat3_data", adat[1], 32'(rom_f(12'h01a)));
            end
        end

        // Reset in the middle of a 3-word locked burst
        do_cycle(1'b1, 4'h0, 4'h0, ad0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'h2, 4'h2, ad0);
        do_cycle(1'b1, 4'h2, 4'h2, ad0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 4'h0, 4'h0, ad0);
            chk("rst_drop_a", 32'(av[0]), 0);
            chk("rst_drop_b", 32'(av[1]), 0);
        end
        do_cycle(1'b0, 4'h9, 4'h0, ad0);
        chk("post_rst_ptr", 32'(s_gnt), 32'h1);

        // Random traffic against the model
        rq = '0;
        lk = '0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 2) != 0) lk = rq & 4'($urandom);
            else lk = 4'($urandom);
            rnd = {$urandom, $urandom};
            do_cycle(rr, rq, lk, rnd[47:0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
